// File: rtl/mips_defs.sv
// mips_defs: shared op/funct encodings and multiply/divide FSM states
package mips_defs;
  typedef enum logic [1:0] {MD_MULT = 2'd0, MD_MULTU = 2'd1, MD_DIV = 2'd2, MD_DIVU = 2'd3} md_op_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FINISH = 2'd2} state_t;
  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: decoder-to-multiply/divide request and HI/LO result bundle
interface muldiv_unit_if;
  import mips_defs::*;
  logic        start;
  md_op_t      op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  modport master (output start, op, operand_a, operand_b, mthi, mtlo,
                  input hi, lo, busy, done, div_by_zero);
  modport slave  (input start, op, operand_a, operand_b, mthi, mtlo,
                  output hi, lo, busy, done, div_by_zero);
endinterface

// File: rtl/hilo_registers.sv
// hilo_registers: architectural HI/LO with op-result and mthi/mtlo write ports
module hilo_registers (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        res_we,
  input  logic [31:0] res_hi,
  input  logic [31:0] res_lo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (res_we) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-cycle shift-add multiply / restoring divide feeding HI/LO
module muldiv_unit
  import mips_defs::*;
(
  input logic          clock,
  input logic          reset_n,
  muldiv_unit_if.slave bus
);
  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [63:0] w, w_next, prod;
  logic [31:0] mcand, a_cap, rem_fix, quo_fix, res_hi, res_lo;
  logic [32:0] rem_sh, sum;
  logic        div_q, sa, sb, dz, is_signed, is_div, neg_a, neg_b, idle, finish;
  assign idle      = state == S_IDLE;
  assign finish    = state == S_FINISH;
  assign is_signed = bus.op == MD_MULT || bus.op == MD_DIV;
  assign is_div    = bus.op == MD_DIV || bus.op == MD_DIVU;
  assign neg_a     = is_signed && bus.operand_a[31];
  assign neg_b     = is_signed && bus.operand_b[31];
  assign bus.busy  = !idle;
  // w is {acc, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    state_n = idle ? (bus.start ? S_RUN : S_IDLE) : state == S_RUN ? (cnt == 5'd31 ? S_FINISH : S_RUN) : S_IDLE;
    rem_sh  = w[63:31];
    sum     = div_q ? rem_sh - {1'b0, mcand} : {1'b0, w[63:32]} + (w[0] ? {1'b0, mcand} : 33'd0);
    w_next  = div_q ? {sum[32] ? rem_sh[31:0] : sum[31:0], w[30:0], !sum[32]} : {sum, w[31:1]};
    prod    = sa ^ sb ? -w : w;
    quo_fix = sa ^ sb ? -w[31:0] : w[31:0];
    rem_fix = sa ? -w[63:32] : w[63:32];
    res_hi  = dz ? a_cap : div_q ? rem_fix : prod[63:32];
    res_lo  = dz ? 32'hFFFF_FFFF : div_q ? quo_fix : prod[31:0];
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt             <= '0;
      w               <= '0;
      mcand           <= '0;
      a_cap           <= '0;
      div_q           <= 1'b0;
      sa              <= 1'b0;
      sb              <= 1'b0;
      dz              <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done        <= finish;
      bus.div_by_zero <= finish && dz;
      if (idle && bus.start) begin
        cnt   <= '0;
        w     <= {32'd0, neg_a ? -bus.operand_a : bus.operand_a};
        mcand <= neg_b ? -bus.operand_b : bus.operand_b;
        a_cap <= bus.operand_a;
        div_q <= is_div;
        sa    <= neg_a;
        sb    <= neg_b;
        dz    <= is_div && bus.operand_b == 32'd0;
      end else if (state == S_RUN) begin
        w   <= w_next;
        cnt <= cnt + 5'd1;
      end
    end
  hilo_registers u_hilo (
    .clock  (clock),
    .reset_n(reset_n),
    .res_we (finish),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .mthi   (idle && !bus.start && bus.mthi),
    .mtlo   (idle && !bus.start && bus.mtlo),
    .wdata  (bus.operand_a),
    .hi     (bus.hi),
    .lo     (bus.lo)
  );
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors against an arithmetic reference of muldiv_unit
module tb_muldiv_unit;
  import mips_defs::*;
  logic clock;
  logic reset_n;
  muldiv_unit_if bus ();
  muldiv_unit dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  int m_left;
  logic [31:0] m_hi, m_lo;
  logic m_done, m_dz;
  logic [64:0] pend;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // reference result as {div_by_zero, hi, lo} from plain arithmetic
  function automatic logic [64:0] model(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    logic [63:0] p;
    if ((o == MD_DIV || o == MD_DIVU) && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    case (o)
      MD_MULT: begin
        q = longint'($signed(a)) * longint'($signed(b));
        return {1'b0, q[63:0]};
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      MD_DIV: begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {1'b0, r[31:0], q[31:0]};
      end
      default: return {1'b0, a % b, a / b};
    endcase
  endfunction
  // cycle model: an accepted op keeps busy for 33 cycles then commits
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      m_left <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dz <= 1'b0; pend <= '0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_left == 0) begin
        if (bus.start) begin
          pend   <= model(bus.op, bus.operand_a, bus.operand_b);
          m_left <= 33;
        end else begin
          if (bus.mthi) m_hi <= bus.operand_a;
          if (bus.mtlo) m_lo <= bus.operand_a;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= pend[63:32]; m_lo <= pend[31:0]; m_dz <= pend[64]; m_done <= 1'b1;
        end
      end
    end
  always @(negedge clock)
    if (reset_n) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, m_left != 0});
      chk("done", {31'd0, bus.done}, {31'd0, m_done});
      chk("dz", {31'd0, bus.div_by_zero}, {31'd0, m_dz});
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
    end
  task automatic do_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int cyc, bcnt;
    @(negedge clock);
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1; bcnt = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) bcnt++;
      @(negedge clock);
      cyc++;
    end
    chk("latency", cyc - 1, 33);
    chk("busy_cycles", bcnt, 33);
    chk("lit_hi", bus.hi, eh);
    chk("lit_lo", bus.lo, el);
    chk("lit_dz", {31'd0, bus.div_by_zero}, {31'd0, edz});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int cyc;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = MD_MULT; bus.operand_a = '0; bus.operand_b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    reset_n = 1'b1;
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    do_op(MD_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
    do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    do_op(MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
    do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    do_op(MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
    do_op(MD_DIV,   32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1);
    // start and mthi while busy must not disturb the run
    @(negedge clock);
    bus.start = 1'b1; bus.op = MD_MULTU; bus.operand_a = 32'd3; bus.operand_b = 32'd4;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    bus.start = 1'b1; bus.mthi = 1'b1; bus.operand_a = 32'hDEAD; bus.operand_b = 32'd9;
    @(negedge clock);
    bus.start = 1'b0; bus.mthi = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 40) begin @(negedge clock); cyc++; end
    chk("midrun_done", {31'd0, bus.done}, 32'd1);
    chk("midrun_hi", bus.hi, 32'd0);
    chk("midrun_lo", bus.lo, 32'd12);
    // reset in the middle of a multu
    @(negedge clock);
    bus.start = 1'b1; bus.op = MD_MULTU; bus.operand_a = 32'hFFFF_FFFF; bus.operand_b = 32'hFFFF_FFFF;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    bus.mtlo = 1'b1; bus.operand_a = 32'h1234;
    @(negedge clock);
    bus.mtlo = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h1234);
    chk("mtlo_hi", bus.hi, 32'd0);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.operand_a = 32'hABCD;
    @(negedge clock);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    chk("both_hi", bus.hi, 32'hABCD);
    chk("both_lo", bus.lo, 32'hABCD);
    // start wins over a simultaneous mthi in IDLE
    @(negedge clock);
    bus.start = 1'b1; bus.mthi = 1'b1; bus.op = MD_MULTU; bus.operand_a = 32'd2; bus.operand_b = 32'd3;
    @(negedge clock);
    bus.start = 1'b0; bus.mthi = 1'b0;
    chk("startwins_hi", bus.hi, 32'hABCD);
    cyc = 0;
    while (!bus.done && cyc < 40) begin @(negedge clock); cyc++; end
    chk("startwins_res_hi", bus.hi, 32'd0);
    chk("startwins_res_lo", bus.lo, 32'd6);
    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
